// File: rtl/vpu_sched_pkg.sv
// Shared types for the VPU command scheduler: opcodes, FSM states, command record.
package vpu_sched_pkg;

  // VPU opcodes live in instr[15:11]; only FILL changes sequencing.
  localparam logic [4:0] OP_DRAW   = 5'b10000;
  localparam logic [4:0] OP_MOVE   = 5'b10001;
  localparam logic [4:0] OP_FILL   = 5'b10010;
  localparam logic [4:0] OP_GETOBJ = 5'b11001;

  localparam int CMD_W = 21;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [15:0] instr;
    logic [4:0]  obj;
  } vpu_cmd_t;

  // FILL is fire-and-forget: strobed on vpu_fill and retired without an ack.
  function automatic logic is_fill(input logic [4:0] op);
    return op == OP_FILL;
  endfunction

endpackage

// File: rtl/vpu_cmd_scheduler_if.sv
// CPU-decode / VPU-facing signal bundle of the command scheduler.
interface vpu_cmd_scheduler_if;
  logic        cmd_valid;
  logic [15:0] cmd_instr;
  logic [4:0]  cmd_obj;
  logic        cmd_stall;
  logic        flush;
  logic        vpu_rdy;
  logic        vpu_start;
  logic        vpu_fill;
  logic [15:0] vpu_instr;
  logic [4:0]  vpu_obj;
  logic        busy;
  logic        ack_err;

  // Environment side: CPU decode plus the VPU ready line.
  modport master (
    output cmd_valid, cmd_instr, cmd_obj, flush, vpu_rdy,
    input  cmd_stall, vpu_start, vpu_fill, vpu_instr, vpu_obj, busy, ack_err
  );

  // Scheduler side.
  modport slave (
    input  cmd_valid, cmd_instr, cmd_obj, flush, vpu_rdy,
    output cmd_stall, vpu_start, vpu_fill, vpu_instr, vpu_obj, busy, ack_err
  );
endinterface

// File: rtl/vpu_cmd_fifo.sv
// Command FIFO: power-of-two depth, flush clears it, push ignored when full,
// pop ignored when empty (so a retire after a flush is silently absorbed).
module vpu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 21
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/vpu_cmd_scheduler.sv
// Queues VPU commands from decode and sequences them into the VPU one at a time:
// IDLE -> ISSUE (strobe) -> ACK (wait rdy low) -> DONE (wait rdy high) -> IDLE.
module vpu_cmd_scheduler
  import vpu_sched_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  vpu_cmd_scheduler_if.slave bus
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  sched_state_e        state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
  vpu_cmd_t            cur_q, cur_d;
  logic                err_q, err_d;
  logic                pop;
  logic                push;
  vpu_cmd_t            head, din;
  logic                full, empty;
  logic [$clog2(DEPTH):0] count;

  assign push = bus.cmd_valid & ~full & ~bus.flush;
  assign din  = '{instr: bus.cmd_instr, obj: bus.cmd_obj};

  vpu_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.flush),
    .din_i   (din),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign cnt_inc = cnt_q + CW'(1);

  // Next-state, retire pop, timeout tracking. The head stays in the FIFO
  // while in flight and is popped on retire. A flush cycle never starts an
  // issue so the flushed head cannot slip through.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    err_d   = err_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty && bus.vpu_rdy && !bus.flush) begin
          cur_d   = head;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d = '0;
        if (is_fill(cur_q.instr[15:11])) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!bus.vpu_rdy) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(ACK_TIMEOUT)) begin
            err_d   = 1'b1;
            pop     = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        if (bus.vpu_rdy) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, in-flight command, timeout counter and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      err_q   <= err_d;
    end
  end

  // Strobes decode from ISSUE so reset kills them immediately.
  assign bus.vpu_start = (state_q == ST_ISSUE) & ~is_fill(cur_q.instr[15:11]);
  assign bus.vpu_fill  = (state_q == ST_ISSUE) &  is_fill(cur_q.instr[15:11]);
  assign bus.vpu_instr = cur_q.instr;
  assign bus.vpu_obj   = cur_q.obj;
  assign bus.cmd_stall = full;
  assign bus.busy      = (count != '0) | (state_q != ST_IDLE);
  assign bus.ack_err   = err_q;
endmodule

// File: tb/tb_vpu_cmd_scheduler.sv
// Bench for vpu_cmd_scheduler: directed tests plus a queue-based reference model.
module tb_vpu_cmd_scheduler;
  import vpu_sched_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vpu_cmd_scheduler_if bus();

  logic rdy_base = 1'b0;
  logic auto_en  = 1'b0;
  int   auto_cnt = 0;
  assign bus.vpu_rdy = rdy_base & (auto_cnt == 0);

  vpu_cmd_scheduler #(.DEPTH(DEPTH), .ACK_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of accepted commands, in-flight record, age since issue.
  vpu_cmd_t mq[$];
  vpu_cmd_t m_cur, m_last;
  bit       m_act, m_acked, m_err;
  int       m_age;

  initial begin
    m_act = 0; m_acked = 0; m_err = 0; m_age = 0; m_last = '0; m_cur = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_act = 0; m_acked = 0; m_err = 0; m_age = 0; m_last = '0;
      end else begin
        bit pop;
        bit push;
        pop  = 0;
        push = bus.cmd_valid && (mq.size() < DEPTH) && !bus.flush;
        if (!m_act) begin
          if (mq.size() > 0 && bus.vpu_rdy && !bus.flush) begin
            m_cur = mq[0]; m_last = mq[0]; m_act = 1; m_age = 0; m_acked = 0;
          end
        end else if (m_age == 0) begin
          if (m_cur.instr[15:11] == 5'b10010) begin pop = 1; m_act = 0; end
          else m_age = 1;
        end else if (m_acked) begin
          if (bus.vpu_rdy) begin pop = 1; m_act = 0; end
        end else if (!bus.vpu_rdy) begin
          m_acked = 1;
        end else if (m_age == TMO) begin
          m_err = 1; pop = 1; m_act = 0;
        end else begin
          m_age++;
        end
        if (bus.flush) mq.delete();
        else begin
          if (pop && mq.size() > 0) void'(mq.pop_front());
          if (push) mq.push_back('{instr: bus.cmd_instr, obj: bus.cmd_obj});
        end
      end
    end
  end

  // Per-cycle compare of every output against the model.
  initial forever begin
    logic [25:0] act, exp;
    logic e_s, e_f;
    @(negedge clk);
    e_s = m_act && m_age == 0 && m_cur.instr[15:11] != 5'b10010;
    e_f = m_act && m_age == 0 && m_cur.instr[15:11] == 5'b10010;
    exp = {mq.size() == DEPTH, (mq.size() != 0) || m_act, e_s, e_f, m_err,
           m_last.instr, m_last.obj};
    act = {bus.cmd_stall, bus.busy, bus.vpu_start, bus.vpu_fill, bus.ack_err,
           bus.vpu_instr, bus.vpu_obj};
    chk("model_cycle", 32'(act), 32'(exp));
  end

  // Strobe log and VPU responder (drops rdy for 2 cycles after a start).
  logic [15:0] slog[$];
  initial forever begin
    @(negedge clk);
    if (bus.vpu_start || bus.vpu_fill) slog.push_back(bus.vpu_instr);
    if (auto_cnt > 0) auto_cnt--;
    if (auto_en && bus.vpu_start) auto_cnt = 2;
  end

  task automatic push(input logic [15:0] i, input logic [4:0] o);
    bit ok = 0;
    bus.cmd_valid = 1'b1; bus.cmd_instr = i; bus.cmd_obj = o;
    for (int n = 0; n < 200; n++) begin
      bit st;
      st = bus.cmd_stall;
      @(negedge clk);
      if (!st) begin ok = 1; break; end
    end
    if (!ok) chk("push_timeout", 32'(0), 32'(1));
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!bus.busy) begin ok = 1; break; end
    end
    if (!ok) chk({name, "_idle_timeout"}, 32'(0), 32'(1));
  endtask

  task automatic wait_strobe(input string name);
    bit ok = 0;
    for (int n = 0; n < 50; n++) begin
      if (bus.vpu_start || bus.vpu_fill) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) chk({name, "_strobe_timeout"}, 32'(0), 32'(1));
  endtask

  initial begin
    logic [15:0] exp3 [5];
    exp3[0] = 16'h8101; exp3[1] = 16'h8802; exp3[2] = 16'hC803;
    exp3[3] = 16'h8904; exp3[4] = 16'h8105;
    bus.cmd_valid = 0; bus.cmd_instr = '0; bus.cmd_obj = '0; bus.flush = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({bus.cmd_stall, bus.busy, bus.vpu_start, bus.vpu_fill,
                           bus.ack_err, bus.vpu_instr, bus.vpu_obj}), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single DRAW with full handshake
    rdy_base = 1;
    push(16'h8005, 5'd3);
    chk("t1_idle_start", 32'(bus.vpu_start), 32'(0));
    chk("t1_idle_busy", 32'(bus.busy), 32'(1));
    @(negedge clk);
    chk("t1_start", 32'(bus.vpu_start), 32'(1));
    chk("t1_instr", 32'(bus.vpu_instr), 32'h8005);
    chk("t1_obj", 32'(bus.vpu_obj), 32'(3));
    rdy_base = 0;
    @(negedge clk);
    chk("t1_start_once", 32'(bus.vpu_start), 32'(0));
    @(negedge clk);
    rdy_base = 1;
    @(negedge clk);
    chk("t1_busy_done", 32'(bus.busy), 32'(0));

    // 2: FILL retires from ISSUE
    push(16'h9003, 5'd7);
    @(negedge clk);
    chk("t2_fill", 32'({bus.vpu_fill, bus.vpu_start}), 32'(2));
    @(negedge clk);
    chk("t2_after", 32'({bus.busy, bus.vpu_fill}), 32'(0));

    // 3: fill FIFO while VPU not ready, 5th stalls, all issue in order
    slog.delete();
    rdy_base = 0; auto_en = 1;
    for (int k = 0; k < 4; k++) push(exp3[k], 5'(k));
    chk("t3_stall", 32'(bus.cmd_stall), 32'(1));
    bus.cmd_valid = 1; bus.cmd_instr = exp3[4]; bus.cmd_obj = 5'd4;
    repeat (3) @(negedge clk);
    chk("t3_stall_held", 32'(bus.cmd_stall), 32'(1));
    rdy_base = 1;
    push(exp3[4], 5'd4);
    wait_idle("t3");
    chk("t3_count", 32'(slog.size()), 32'(5));
    for (int k = 0; k < 5 && k < slog.size(); k++)
      chk("t3_order", 32'(slog[k]), 32'(exp3[k]));

    // 4: ack timeout with rdy stuck high
    auto_en = 0; rdy_base = 1;
    push(16'h8011, 5'd1);
    push(16'h8022, 5'd2);
    chk("t4_start_x", 32'({bus.vpu_start, bus.vpu_instr}), 32'h18011);
    repeat (TMO) @(negedge clk);
    chk("t4_err_pre", 32'(bus.ack_err), 32'(0));
    @(negedge clk);
    chk("t4_err_set", 32'({bus.ack_err, bus.busy}), 32'(3));
    auto_en = 1;
    @(negedge clk);
    chk("t4_start_y", 32'({bus.vpu_start, bus.vpu_instr}), 32'h18022);
    wait_idle("t4");
    chk("t4_err_sticky", 32'(bus.ack_err), 32'(1));

    // 5: flush with 3 queued, 1 in flight
    slog.delete();
    rdy_base = 0;
    for (int k = 0; k < 4; k++) push(16'h8A00 + 16'(k), 5'(k));
    rdy_base = 1;
    wait_strobe("t5");
    bus.flush = 1;
    @(negedge clk);
    bus.flush = 0;
    chk("t5_flushed", 32'({bus.cmd_stall, bus.busy}), 32'(1));
    wait_idle("t5");
    repeat (10) @(negedge clk);
    chk("t5_one_strobe", 32'(slog.size()), 32'(1));
    if (slog.size() > 0) chk("t5_first", 32'(slog[0]), 32'h8A00);
    chk("t5_idle", 32'(bus.busy), 32'(0));

    // 6: reset during ACK
    slog.delete();
    auto_en = 0; rdy_base = 1;
    push(16'h8044, 5'd4);
    push(16'h8055, 5'd5);
    @(negedge clk);
    #2 rst_n = 0;
    #1 chk("t6_reset_outs", 32'({bus.cmd_stall, bus.busy, bus.vpu_start, bus.vpu_fill,
                                  bus.ack_err, bus.vpu_instr, bus.vpu_obj}), 32'(0));
    slog.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (20) @(negedge clk);
    chk("t6_no_strobe", 32'(slog.size()), 32'(0));
    chk("t6_idle", 32'(bus.busy), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
